// File: rtl/cnn_dnn_sequencer.sv
// cnn_dnn_sequencer
//
// Drives a top_v2 CNN+DNN core through one inference:
//   1. LOAD      : streams weight row beats into each DNN layer in order and
//                  raises the matching one-hot load strobe one cycle later.
//   2. STREAM    : passes exactly one image of pixels to the core. The core's
//                  ready signal applies back-pressure combinationally.
//   3. WAIT_DONE : waits for the core's completion pulse.
//   4. FINISH    : one-cycle done pulse, then back to IDLE.
//
// Ports
//   clk, res_n                      clock, asynchronous active-low reset
//   start, skip_load                run request (IDLE only); skip_load keeps old weights
//   w_valid, w_data, w_ready        weight row beat source handshake
//   out_weights, out_load_weights   registered weight word and per-layer load strobe
//   px_valid, px_data, px_ready     pixel source handshake
//   core_ready, core_valid,
//   core_data, core_done            top_v2 pixel handshake and completion pulse
//   busy, done                      status: not idle / completion pulse
module cnn_dnn_sequencer #(
    parameter int NumLayers    = 2,
    parameter int MaxNumNerves = 4,
    parameter int M_W_BitSize  = 4,
    parameter int BitSize      = 4,
    parameter int ImageWidth   = 8,
    parameter int LoadRows [NumLayers-1:0] = '{4, 4}
) (
    input  logic                                clk,
    input  logic                                res_n,
    input  logic                                start,
    input  logic                                skip_load,
    input  logic                                w_valid,
    input  logic [MaxNumNerves*M_W_BitSize-1:0] w_data,
    output logic                                w_ready,
    output logic [MaxNumNerves*M_W_BitSize-1:0] out_weights,
    output logic [NumLayers-1:0]                out_load_weights,
    input  logic                                px_valid,
    input  logic [BitSize-1:0]                  px_data,
    output logic                                px_ready,
    input  logic                                core_ready,
    output logic                                core_valid,
    output logic [BitSize-1:0]                  core_data,
    input  logic                                core_done,
    output logic                                busy,
    output logic                                done
);

    localparam int NumPixels = ImageWidth * ImageWidth;

    function automatic int max_rows();
        int m = 1;
        for (int i = 0; i < NumLayers; i++) begin
            if (LoadRows[i] > m) m = LoadRows[i];
        end
        return m;
    endfunction

    localparam int RowW   = $clog2(max_rows() + 1);
    localparam int PixW   = $clog2(NumPixels + 1);
    localparam int LayerW = (NumLayers > 1) ? $clog2(NumLayers) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        WAIT_DONE,
        FINISH
    } state_e;

    state_e            state, state_nxt;
    logic [RowW-1:0]   row, row_nxt;
    logic [LayerW-1:0] layer, layer_nxt;
    logic [PixW-1:0]   pix_cnt, pix_nxt;
    logic              done_seen, done_seen_nxt;
    logic              w_accept;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        row_nxt       = row;
        layer_nxt     = layer;
        pix_nxt       = pix_cnt;
        done_seen_nxt = done_seen;
        w_accept      = 1'b0;
        w_ready       = 1'b0;
        px_ready      = 1'b0;
        core_valid    = 1'b0;
        core_data     = '0;
        busy          = (state != IDLE);
        done          = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (skip_load) begin
                        state_nxt     = STREAM;
                        pix_nxt       = '0;
                        done_seen_nxt = 1'b0;
                    end else begin
                        state_nxt = LOAD;
                        row_nxt   = '0;
                        layer_nxt = '0;
                    end
                end
            end

            LOAD: begin
                w_ready  = 1'b1;
                w_accept = w_valid;
                if (w_accept) begin
                    if (int'(row) == LoadRows[layer] - 1) begin
                        row_nxt = '0;
                        if (int'(layer) == NumLayers - 1) begin
                            state_nxt     = STREAM;
                            pix_nxt       = '0;
                            done_seen_nxt = 1'b0;
                        end else begin
                            layer_nxt = layer + 1'b1;
                        end
                    end else begin
                        row_nxt = row + 1'b1;
                    end
                end
            end

            STREAM: begin
                px_ready   = core_ready;
                core_valid = px_valid & core_ready;
                core_data  = px_data;
                // Captured here as well as in WAIT_DONE so a completion pulse
                // that coincides with the last pixel is not lost.
                if (core_done) done_seen_nxt = 1'b1;
                if (px_valid && core_ready) begin
                    pix_nxt = pix_cnt + 1'b1;
                    if (int'(pix_cnt) == NumPixels - 1) state_nxt = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                if (core_done) done_seen_nxt = 1'b1;
                if (done_seen) state_nxt = FINISH;
            end

            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state            <= IDLE;
            row              <= '0;
            layer            <= '0;
            pix_cnt          <= '0;
            done_seen        <= 1'b0;
            out_weights      <= '0;
            out_load_weights <= '0;
        end else begin
            state     <= state_nxt;
            row       <= row_nxt;
            layer     <= layer_nxt;
            pix_cnt   <= pix_nxt;
            done_seen <= done_seen_nxt;
            // The strobe is a one-cycle pulse per accepted beat; the weight
            // word holds between beats so the core sees stable data.
            if (w_accept) begin
                out_weights      <= w_data;
                out_load_weights <= NumLayers'(1) << layer;
            end else begin
                out_load_weights <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cnn_dnn_sequencer.sv
// Self-checking bench for cnn_dnn_sequencer: random stimulus compared each
// cycle against a phase-level reference model; directed jobs cover the
// loading order, back-pressure, completion latency, skip_load and mid-load reset.
module tb_cnn_dnn_sequencer;

    localparam int NumLayers    = 2;
    localparam int MaxNumNerves = 4;
    localparam int M_W_BitSize  = 4;
    localparam int BitSize      = 4;
    localparam int ImageWidth   = 8;
    localparam int LoadRows [NumLayers-1:0] = '{4, 4};
    localparam int WW        = MaxNumNerves * M_W_BitSize;
    localparam int NumPixels = ImageWidth * ImageWidth;

    logic                 clk = 1'b0;
    logic                 res_n = 1'b0;
    logic                 start = 1'b0, skip_load = 1'b0;
    logic                 w_valid = 1'b0;
    logic [WW-1:0]        w_data = '0;
    logic                 w_ready;
    logic [WW-1:0]        out_weights;
    logic [NumLayers-1:0] out_load_weights;
    logic                 px_valid = 1'b0;
    logic [BitSize-1:0]   px_data = '0;
    logic                 px_ready;
    logic                 core_ready = 1'b0;
    logic                 core_valid;
    logic [BitSize-1:0]   core_data;
    logic                 core_done = 1'b0;
    logic                 busy, done;

    cnn_dnn_sequencer #(
        .NumLayers(NumLayers), .MaxNumNerves(MaxNumNerves), .M_W_BitSize(M_W_BitSize),
        .BitSize(BitSize), .ImageWidth(ImageWidth), .LoadRows(LoadRows)
    ) dut (
        .clk(clk), .res_n(res_n), .start(start), .skip_load(skip_load),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .out_weights(out_weights), .out_load_weights(out_load_weights),
        .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
        .core_ready(core_ready), .core_valid(core_valid), .core_data(core_data),
        .core_done(core_done), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef enum {P_IDLE, P_LOAD, P_STREAM, P_WAIT, P_FINISH} phase_e;
    phase_e               ph;
    int                   beats, pix;
    bit                   dflag;
    logic [NumLayers-1:0] e_lw;
    logic [WW-1:0]        e_w;
    int                   total_rows;
    logic [BitSize-1:0]   img [NumPixels];

    int errors = 0, checks = 0;
    int scnt [NumLayers];
    int pix_seen;
    logic obs_done, obs_busy;
    int sc;

    // Which layer the k-th beat of a load belongs to (layer 0 loaded first).
    function automatic int layer_of(input int k);
        int acc = 0;
        for (int l = 0; l < NumLayers; l++) begin
            acc += LoadRows[l];
            if (k < acc) return l;
        end
        return NumLayers - 1;
    endfunction

    task automatic model_reset();
        ph = P_IDLE; beats = 0; pix = 0; dflag = 1'b0; e_lw = '0; e_w = '0;
    endtask

    task automatic enter_stream();
        ph = P_STREAM; pix = 0; dflag = 1'b0;
    endtask

    task automatic model_edge();
        logic [NumLayers-1:0] nlw;
        nlw = '0;
        if (!res_n) begin
            model_reset();
            return;
        end
        case (ph)
            P_IDLE: if (start) begin
                if (skip_load) enter_stream();
                else begin ph = P_LOAD; beats = 0; end
            end
            P_LOAD: if (w_valid) begin
                nlw = NumLayers'(1) << layer_of(beats);
                e_w = w_data;
                beats++;
                if (beats == total_rows) enter_stream();
            end
            P_STREAM: begin
                if (core_done) dflag = 1'b1;
                if (px_valid && core_ready) begin
                    pix++;
                    if (pix == NumPixels) ph = P_WAIT;
                end
            end
            P_WAIT: begin
                if (dflag) ph = P_FINISH;
                else if (core_done) dflag = 1'b1;
            end
            P_FINISH: ph = P_IDLE;
            default: ph = P_IDLE;
        endcase
        e_lw = nlw;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [NumLayers-1:0] one;
        check("w_ready", 32'(w_ready), 32'(ph == P_LOAD));
        check("px_ready", 32'(px_ready), 32'(ph == P_STREAM && core_ready));
        check("core_valid", 32'(core_valid), 32'(ph == P_STREAM && core_ready && px_valid));
        check("core_data", 32'(core_data), (ph == P_STREAM) ? 32'(px_data) : 32'd0);
        check("busy", 32'(busy), 32'(ph != P_IDLE));
        check("done", 32'(done), 32'(ph == P_FINISH));
        check("load_weights", 32'(out_load_weights), 32'(e_lw));
        check("weights", 32'(out_weights), 32'(e_w));
        for (int l = 0; l < NumLayers; l++) begin
            one = NumLayers'(1) << l;
            if (out_load_weights === one) scnt[l]++;
        end
        if (core_valid === 1'b1) pix_seen++;
        obs_done = done;
        obs_busy = busy;
    endtask

    // Called right after a falling edge with inputs applied.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        if (ph == P_STREAM) sc++;
        @(negedge clk);
    endtask

    task automatic drive(input int n, input bit skip, input int wmode, input int cmode, input int dmode);
        start     = (n == 0) ? 1'b1 : (ph != P_IDLE && $urandom_range(0, 7) == 0);
        skip_load = (n == 0) ? skip : 1'($urandom_range(0, 1));
        w_data    = WW'($urandom);
        case (wmode)
            0: w_valid = 1'b1;
            1: w_valid = (n % 2 == 1);
            default: w_valid = ($urandom_range(0, 2) != 0);
        endcase
        case (cmode)
            0: core_ready = 1'b1;
            1: core_ready = (sc % 4 < 2);
            default: core_ready = ($urandom_range(0, 2) != 0);
        endcase
        px_valid = (cmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        px_data  = (ph == P_STREAM && pix < NumPixels) ? img[pix] : BitSize'($urandom);
        if (ph == P_IDLE || ph == P_LOAD || ph == P_FINISH)
            core_done = ($urandom_range(0, 3) == 0);   // must be ignored
        else if (dmode == 0)
            core_done = (ph == P_STREAM && pix == NumPixels - 1 && px_valid && core_ready);
        else if (ph == P_WAIT)
            core_done = ($urandom_range(0, 2) == 0);
        else
            core_done = ($urandom_range(0, 39) == 0);
    endtask

    task automatic clear_counts();
        for (int l = 0; l < NumLayers; l++) scnt[l] = 0;
        pix_seen = 0;
        sc = 0;
        for (int i = 0; i < NumPixels; i++) img[i] = BitSize'($urandom);
    endtask

    task automatic run_job(input string name, input bit skip, input int wmode, input int cmode, input int dmode);
        int acc64 = -1, done_cyc = -1, idle_cyc = -1;
        bit fin = 1'b0;
        clear_counts();
        for (int n = 0; n < 800 && !fin; n++) begin
            drive(n, skip, wmode, cmode, dmode);
            if (ph == P_STREAM && pix == NumPixels - 1 && px_valid && core_ready) acc64 = n;
            cycle();
            if (obs_done === 1'b1) done_cyc = n;
            if (done_cyc >= 0 && n > done_cyc && obs_busy === 1'b0) begin
                idle_cyc = n;
                fin = 1'b1;
            end
        end
        check({name, "_finished"}, 32'(fin), 32'd1);
        for (int l = 0; l < NumLayers; l++)
            check($sformatf("%s_strobes_l%0d", name, l), scnt[l], skip ? 0 : LoadRows[l]);
        check({name, "_pixels"}, pix_seen, NumPixels);
        if (dmode == 0) begin
            check({name, "_done_lat"}, done_cyc - acc64, 2);
            check({name, "_busy_fall"}, idle_cyc - acc64, 3);
        end
        if (!skip && wmode == 0 && cmode == 0)
            check({name, "_start_to_done"}, done_cyc + 1, 1 + total_rows + NumPixels + 2);
        start = 1'b0; w_valid = 1'b0; px_valid = 1'b0; core_done = 1'b0;
    endtask

    initial begin
        total_rows = 0;
        for (int l = 0; l < NumLayers; l++) total_rows += LoadRows[l];
        model_reset();
        clear_counts();
        @(negedge clk);

        // Reset state
        cycle();
        cycle();
        res_n = 1'b1;
        cycle();

        run_job("full", 1'b0, 0, 0, 0);
        run_job("toggle", 1'b0, 1, 1, 0);
        run_job("random", 1'b0, 2, 2, 1);
        run_job("skip", 1'b1, 0, 2, 1);

        // Reset after two beats of layer 1, then a fresh reload.
        clear_counts();
        for (int n = 0; n < 1 + LoadRows[0] + 2; n++) begin
            drive(n, 1'b0, 0, 0, 0);
            cycle();
        end
        check("pre_reset_strobe", 32'(out_load_weights), 32'(NumLayers'(1) << 1));
        res_n = 1'b0;
        #1;
        check("rst_load_weights", 32'(out_load_weights), 32'd0);
        check("rst_weights", 32'(out_weights), 32'd0);
        check("rst_w_ready", 32'(w_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        model_reset();
        w_valid = 1'b0; start = 1'b0; core_done = 1'b0;
        cycle();
        res_n = 1'b1;
        cycle();
        run_job("after_reset", 1'b0, 0, 0, 0);

        for (int j = 0; j < 4; j++)
            run_job($sformatf("rand%0d", j), 1'($urandom_range(0, 1)), 2, 2, j % 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
